// File: rtl/e_key_generator_param_if.sv
// Request/result bundle between the RSA exponent generator and its user/RNG.
// The master drives the request and RNG word; the slave returns the exponent and status.
interface e_key_generator_param_if #(
   parameter int unsigned WIDTH = 32
);
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] phi;
   logic [WIDTH-1:0] rng_e;
   logic             rng_en;
   logic             valid;
   logic             fail;
   logic             busy;
   logic [WIDTH-1:0] e_key;

   modport master (
      output en, mode, phi, rng_e,
      input  rng_en, valid, fail, busy, e_key
   );

   modport slave (
      input  en, mode, phi, rng_e,
      output rng_en, valid, fail, busy, e_key
   );
endinterface

// File: rtl/e_key_generator_param.sv
// RSA public-exponent generator: picks an odd candidate (fixed or random) and
// accepts it once a one-step-per-cycle binary GCD against phi reaches 1.
module e_key_generator_param #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_TRIES = 16,
   parameter int unsigned FIXED_E   = 65537
) (
   input  logic                     clk,
   input  logic                     rst,
   e_key_generator_param_if.slave   bus
);
   localparam int unsigned      TW      = $clog2(MAX_TRIES + 1);
   localparam logic [WIDTH-1:0] FIXED_W = WIDTH'(FIXED_E);
   localparam logic [TW-1:0]    MAX_T   = TW'(MAX_TRIES);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] THREE   = WIDTH'(3);
   localparam logic [WIDTH-1:0] FIVE    = WIDTH'(5);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_CAP, S_CHK, S_GCD, S_DONE, S_FAIL
   } state_t;

   state_t           r_state, w_state_nx, w_rej_st;
   logic [WIDTH-1:0] r_phi, r_cand, r_a, r_b;
   logic [TW-1:0]    r_tries;
   logic             r_fixed;

   logic             r_rng_en, r_valid, r_fail, r_busy;
   logic [WIDTH-1:0] r_e_key;
   logic             w_rng_en_nx, w_valid_nx, w_fail_nx, w_busy_nx;
   logic [WIDTH-1:0] w_e_key_nx;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   // Next state; the fixed exponent never consumes a try
   always_comb begin
      w_rej_st   = (r_fixed || (r_tries < MAX_T)) ? S_REQ : S_FAIL;
      w_state_nx = r_state;
      if (!bus.en) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.phi < FIVE)                       w_state_nx = S_FAIL;
               else if (bus.mode && (FIXED_W < bus.phi)) w_state_nx = S_CHK;
               else                                      w_state_nx = S_REQ;
            end
            S_REQ:  w_state_nx = S_CAP;
            S_CAP:  w_state_nx = S_CHK;
            S_CHK: begin
               if ((r_cand < THREE) || (r_cand >= r_phi)) w_state_nx = w_rej_st;
               else                                       w_state_nx = S_GCD;
            end
            S_GCD: begin
               if (r_a == r_b) w_state_nx = (r_a == ONE) ? S_DONE : w_rej_st;
            end
            S_DONE:  w_state_nx = S_DONE;
            S_FAIL:  w_state_nx = S_FAIL;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   // Outputs track the state being entered so they line up with it
   always_comb begin
      w_rng_en_nx = (w_state_nx == S_REQ);
      w_busy_nx   = (w_state_nx == S_REQ) || (w_state_nx == S_CAP) ||
                    (w_state_nx == S_CHK) || (w_state_nx == S_GCD);
      w_valid_nx  = (w_state_nx == S_DONE);
      w_fail_nx   = (w_state_nx == S_FAIL);
      w_e_key_nx  = (w_state_nx == S_DONE) ? r_cand : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rng_en <= 1'b0;
         r_valid  <= 1'b0;
         r_fail   <= 1'b0;
         r_busy   <= 1'b0;
         r_e_key  <= '0;
      end else begin
         r_rng_en <= w_rng_en_nx;
         r_valid  <= w_valid_nx;
         r_fail   <= w_fail_nx;
         r_busy   <= w_busy_nx;
         r_e_key  <= w_e_key_nx;
      end
   end

   // Candidate, try counter and GCD datapath; cand is always odd so no 2^k tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phi   <= '0;
         r_cand  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_tries <= '0;
         r_fixed <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.en) begin
                  r_phi   <= bus.phi;
                  r_tries <= '0;
                  r_cand  <= FIXED_W;
                  r_fixed <= 1'b1;
               end
            end
            S_CAP: begin
               r_cand  <= bus.rng_e | ONE;
               r_fixed <= 1'b0;
               r_tries <= r_tries + TW'(1);
            end
            S_CHK: begin
               r_a <= r_phi;
               r_b <= r_cand;
            end
            S_GCD: begin
               if (r_a != r_b) begin
                  if (!r_a[0])        r_a <= r_a >> 1;
                  else if (!r_b[0])   r_b <= r_b >> 1;
                  else if (r_a > r_b) r_a <= (r_a - r_b) >> 1;
                  else                r_b <= (r_b - r_a) >> 1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rng_en = r_rng_en;
   assign bus.valid  = r_valid;
   assign bus.fail   = r_fail;
   assign bus.busy   = r_busy;
   assign bus.e_key  = r_e_key;
endmodule
